// File: rtl/arbiter_match_ctrl_if.sv
// Signal bundle between the match controller and the player inputs,
// countdown block, winner block and LED mux.
interface arbiter_match_ctrl_if #(
    parameter int SCORE_W = 2
);
    logic               req1;
    logic               req2;
    logic               cd_done;
    logic               w_done;
    logic               cd_rst;
    logic               w_rst;
    logic               gnt1;
    logic               gnt2;
    logic               leds_rst;
    logic               leds_sel;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic               match_over;
    logic [1:0]         champion;

    modport master (
        input  req1, req2, cd_done, w_done,
        output cd_rst, w_rst, gnt1, gnt2, leds_rst, leds_sel,
               score1, score2, match_over, champion
    );

    modport slave (
        output req1, req2, cd_done, w_done,
        input  cd_rst, w_rst, gnt1, gnt2, leds_rst, leds_sel,
               score1, score2, match_over, champion
    );
endinterface

// File: rtl/arbiter_match_ctrl.sv
// Match-level controller for the two-player reaction game: sequences rounds,
// arbitrates presses (false starts, ties), keeps scores and names a champion.
module arbiter_match_ctrl #(
    parameter int ROUNDS_TO_WIN = 3,
    parameter int SCORE_W       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    arbiter_match_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, ARM, COUNT, RACE, SHOW, SCORE, DONE} state_t;

    localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(ROUNDS_TO_WIN);

    state_t             state, state_nx;
    logic               prio, prio_nx;
    logic               win2, win2_nx;
    logic [SCORE_W-1:0] score1_nx, score2_nx, inc1, inc2;
    logic [1:0]         champion_nx;
    logic               cd_rst_nx, w_rst_nx, leds_rst_nx, leds_sel_nx;
    logic               gnt1_nx, gnt2_nx, match_over_nx;
    logic               any_req, both_req, race_win2;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign any_req   = bus.req1 | bus.req2;
    assign both_req  = bus.req1 & bus.req2;
    // Player 2 takes a race press when alone, or on a tie while it holds priority.
    assign race_win2 = bus.req2 & (~bus.req1 | prio);
    assign inc1      = sat_inc(bus.score1);
    assign inc2      = sat_inc(bus.score2);

    always_comb begin
        state_nx    = state;
        prio_nx     = prio;
        win2_nx     = win2;
        score1_nx   = bus.score1;
        score2_nx   = bus.score2;
        champion_nx = bus.champion;
        case (state)
            IDLE:  state_nx = ARM;
            ARM:   if (!any_req) state_nx = COUNT;
            COUNT: begin
                if (bus.cd_done && any_req) begin
                    state_nx = SHOW;
                    win2_nx  = race_win2;
                end else if (bus.cd_done) begin
                    state_nx = RACE;
                end else if (both_req) begin
                    state_nx = ARM;
                end else if (any_req) begin
                    // False start hands the round to the other player.
                    state_nx = SHOW;
                    win2_nx  = bus.req1;
                end
            end
            RACE: begin
                if (any_req) begin
                    state_nx = SHOW;
                    win2_nx  = race_win2;
                end
            end
            SHOW:  if (bus.w_done) state_nx = SCORE;
            SCORE: begin
                prio_nx = ~win2;
                if (win2) score2_nx = inc2;
                else      score1_nx = inc1;
                if ((win2 ? inc2 : inc1) == WIN_SCORE) begin
                    state_nx    = DONE;
                    champion_nx = win2 ? 2'b10 : 2'b01;
                end else begin
                    state_nx = ARM;
                end
            end
            DONE: begin
                if (both_req) begin
                    state_nx    = ARM;
                    score1_nx   = '0;
                    score2_nx   = '0;
                    champion_nx = 2'b00;
                    prio_nx     = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Outputs are registered from the state being entered.
        cd_rst_nx     = !(state_nx inside {COUNT, RACE, SHOW});
        w_rst_nx      = !(state_nx inside {SHOW, DONE});
        leds_rst_nx   = state_nx inside {IDLE, ARM};
        leds_sel_nx   = state_nx inside {SHOW, DONE};
        match_over_nx = (state_nx == DONE);
        gnt1_nx       = ((state_nx == SHOW) && !win2_nx) ||
                        ((state_nx == DONE) && (champion_nx == 2'b01));
        gnt2_nx       = ((state_nx == SHOW) && win2_nx) ||
                        ((state_nx == DONE) && (champion_nx == 2'b10));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            prio           <= 1'b0;
            bus.cd_rst     <= 1'b1;
            bus.w_rst      <= 1'b1;
            bus.leds_rst   <= 1'b1;
            bus.leds_sel   <= 1'b0;
            bus.gnt1       <= 1'b0;
            bus.gnt2       <= 1'b0;
            bus.match_over <= 1'b0;
            bus.champion   <= 2'b00;
            bus.score1     <= '0;
            bus.score2     <= '0;
        end else begin
            state          <= state_nx;
            prio           <= prio_nx;
            bus.cd_rst     <= cd_rst_nx;
            bus.w_rst      <= w_rst_nx;
            bus.leds_rst   <= leds_rst_nx;
            bus.leds_sel   <= leds_sel_nx;
            bus.gnt1       <= gnt1_nx;
            bus.gnt2       <= gnt2_nx;
            bus.match_over <= match_over_nx;
            bus.champion   <= champion_nx;
            bus.score1     <= score1_nx;
            bus.score2     <= score2_nx;
        end
    end

    // Round winner is only consulted after it has been written on entry to SHOW.
    always_ff @(posedge clk) begin
        win2 <= win2_nx;
    end
endmodule
